// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words, writes them
// from word address 0 upward, and holds the processor in reset until the image is complete.
module imem_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done
);

  localparam int unsigned    DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [ADDR_W:0] wcnt_inc;
  logic [ADDR_W:0] len_clamped;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [31:0]     wd_q, wd_d;
  logic            done_q, done_d;

  assign len_clamped = (load_len > DEPTH_V) ? DEPTH_V : load_len;
  assign wcnt_inc    = wcnt_q + (ADDR_W + 1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d  = len_clamped;
          wcnt_d = '0;
          bcnt_d = '0;
          if (len_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (in_valid) begin
          wd_d   = {wd_q[23:0], in_byte};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        wcnt_d = wcnt_inc;
        if (wcnt_inc == len_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and data are held in registers, so they are stable for the whole write cycle.
  assign in_ready  = (state_q == RECV);
  assign imem_we   = (state_q == WRITE);
  assign imem_addr = wcnt_q[ADDR_W-1:0];
  assign imem_wd   = wd_q;
  assign cpu_reset = (state_q != DONE);
  assign busy      = (state_q == RECV) || (state_q == WRITE);
  assign done      = done_q;

endmodule
